// File: rtl/pcm_rr_arbiter.sv
// pcm_rr_arbiter
//   Round-robin arbiter and sequencer that shares one PCM memory-mapped slave
//   among N_REQ CPU requesters. One request is accepted at a time with a
//   valid/ready handshake. The arbiter then runs one memory cycle for it and
//   returns a one-cycle completion pulse to the requester that won.
//
// Ports
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   req_valid/req_write    per-requester request and direction (1 = write)
//   req_addr/req_wdata     packed per-requester address / write data
//   req_ready              one-hot accept strobe (combinational, IDLE only)
//   rsp_valid              one-hot completion pulse (registered, DONE only)
//   rsp_rdata              last read data, shared by all requesters
//   pcm_mem_mm_*           memory-mapped slave interface
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | pick the round-robin winner, accept it, latch its request
// ISSUE   | one memory cycle with chipselect; write strobe if a write
// WAIT_RD | read in flight, count RD_LAT cycles, capture readdata
// DONE    | completion pulse to the winner, advance round-robin pointer

module pcm_rr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_write,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         pcm_mem_mm_address,
    output logic                      pcm_mem_mm_chipselect,
    output logic                      pcm_mem_mm_clken,
    output logic                      pcm_mem_mm_write,
    input  logic [DATA_W-1:0]         pcm_mem_mm_readdata,
    output logic [DATA_W-1:0]         pcm_mem_mm_writedata,
    output logic [DATA_W/8-1:0]       pcm_mem_mm_byteenable
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

    state_t        state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] winner_q;
    logic [GW-1:0] win_idx;
    logic [GW-1:0] scan_idx;
    logic          win_any;
    logic [3:0]    cnt;

    assign pcm_mem_mm_clken      = 1'b1;
    assign pcm_mem_mm_byteenable = '1;

    // Scan from the farthest candidate back to the nearest, so the last hit
    // (the one closest after last_grant) is the winner.
    always_comb begin
        win_any  = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            scan_idx = GW'((int'(last_grant) + k) % N_REQ);
            if (req_valid[scan_idx]) begin
                win_any = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && win_any)
            req_ready[win_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                 <= IDLE;
            last_grant            <= GW'(N_REQ - 1);
            winner_q              <= '0;
            cnt                   <= '0;
            pcm_mem_mm_address    <= '0;
            pcm_mem_mm_writedata  <= '0;
            pcm_mem_mm_write      <= 1'b0;
            pcm_mem_mm_chipselect <= 1'b0;
            rsp_valid             <= '0;
            rsp_rdata             <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        winner_q              <= win_idx;
                        pcm_mem_mm_address    <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                        pcm_mem_mm_writedata  <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
                        pcm_mem_mm_write      <= req_write[win_idx];
                        pcm_mem_mm_chipselect <= 1'b1;
                        state                 <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The write strobe register doubles as the latched direction.
                    pcm_mem_mm_write <= 1'b0;
                    if (pcm_mem_mm_write) begin
                        pcm_mem_mm_chipselect <= 1'b0;
                        rsp_valid             <= ONE << winner_q;
                        state                 <= DONE;
                    end else begin
                        cnt   <= 4'(RD_LAT);
                        state <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        rsp_rdata             <= pcm_mem_mm_readdata;
                        pcm_mem_mm_chipselect <= 1'b0;
                        rsp_valid             <= ONE << winner_q;
                        state                 <= DONE;
                    end
                end
                DONE: begin
                    last_grant <= winner_q;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
